stage1_decompressor: RTL and testbench

Stage-1 decompressor: the receive-side inverse of the stage-1 compressor's comparator/encoder path. It accepts one MSB-aligned dictionary code per beat, rebuilds the original 32-bit word, and keeps a 16-entry × 32-bit dictionary updated with exactly the same push rule the compressor uses, so the two dictionaries stay in lock-step. It sits between the bit-unpacker, which consumes `code_len_o` to advance its shift window, and the word sink.

---
 rtl/cpack_pkg.sv | 72 +++++++
 rtl/cpack_dictionary.sv | 40 ++++
 rtl/stage1_decompressor.sv | 86 ++++++++
 tb/tb_stage1_decompressor.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpack_pkg.sv
// Shared stage-1 compressor/decompressor definitions: prefix encodings,
// code lengths, the code classification and the dictionary push rule.
package cpack_pkg;

    localparam int unsigned CP_WIDTH = 32;
    localparam int unsigned CP_WORDS = 16;

    // Two-bit prefixes
    localparam logic [1:0] CP_ZZZZ = 2'b00;
    localparam logic [1:0] CP_XXXX = 2'b01;
    localparam logic [1:0] CP_MMMM = 2'b10;
    // Four-bit prefixes
    localparam logic [3:0] CP_MMXX = 4'b1100;
    localparam logic [3:0] CP_ZZZX = 4'b1101;
    localparam logic [3:0] CP_MMMX = 4'b1110;

    localparam logic [5:0] CP_LEN_ZZZZ    = 6'd2;
    localparam logic [5:0] CP_LEN_XXXX    = 6'd34;
    localparam logic [5:0] CP_LEN_MMMM    = 6'd6;
    localparam logic [5:0] CP_LEN_MMXX    = 6'd24;
    localparam logic [5:0] CP_LEN_ZZZX    = 6'd12;
    localparam logic [5:0] CP_LEN_MMMX    = 6'd16;
    localparam logic [5:0] CP_LEN_ILLEGAL = 6'd4;

    typedef enum logic [2:0] {
        CP_C_ZZZZ,
        CP_C_XXXX,
        CP_C_MMMM,
        CP_C_MMXX,
        CP_C_ZZZX,
        CP_C_MMMX,
        CP_C_ILLEGAL
    } cp_code_e;

    // Classify a code from its four MSBs
    function automatic cp_code_e cp_classify(input logic [3:0] prefix);
        cp_code_e kind;
        if (prefix[3:2] == CP_ZZZZ)      kind = CP_C_ZZZZ;
        else if (prefix[3:2] == CP_XXXX) kind = CP_C_XXXX;
        else if (prefix[3:2] == CP_MMMM) kind = CP_C_MMMM;
        else if (prefix == CP_MMXX)      kind = CP_C_MMXX;
        else if (prefix == CP_ZZZX)      kind = CP_C_ZZZX;
        else if (prefix == CP_MMMX)      kind = CP_C_MMMX;
        else                             kind = CP_C_ILLEGAL;
        return kind;
    endfunction

    function automatic logic [5:0] cp_code_len(input cp_code_e kind);
        logic [5:0] len;
        case (kind)
            CP_C_ZZZZ: len = CP_LEN_ZZZZ;
            CP_C_XXXX: len = CP_LEN_XXXX;
            CP_C_MMMM: len = CP_LEN_MMMM;
            CP_C_MMXX: len = CP_LEN_MMXX;
            CP_C_ZZZX: len = CP_LEN_ZZZX;
            CP_C_MMMX: len = CP_LEN_MMMX;
            default:   len = CP_LEN_ILLEGAL;
        endcase
        return len;
    endfunction

    // Only codes carrying new literal bits enter the dictionary
    function automatic logic cp_pushes(input cp_code_e kind);
        logic push;
        case (kind)
            CP_C_XXXX, CP_C_MMXX, CP_C_MMMX: push = 1'b1;
            default:                         push = 1'b0;
        endcase
        return push;
    endfunction

endpackage

// File: rtl/cpack_dictionary.sv
// Circular word dictionary: push writes at wr_ptr and advances it,
// flush clears all entries; one combinational read port.
module cpack_dictionary
    import cpack_pkg::*;
#(
    parameter int unsigned WIDTH = CP_WIDTH,
    parameter int unsigned WORDS = CP_WORDS,
    parameter int unsigned IDX_W = $clog2(WORDS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_word_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [WIDTH-1:0] rd_word_o
);

    logic [WIDTH-1:0] entries [WORDS];
    logic [IDX_W-1:0] wr_ptr;

    // Entry storage and write pointer; reset and flush clear everything
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                entries[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (push_i) begin
            entries[wr_ptr] <= push_word_i;
            wr_ptr <= (wr_ptr == IDX_W'(WORDS - 1)) ? '0 : wr_ptr + IDX_W'(1);
        end
    end

    // Read reflects the state before this cycle's push
    always_comb begin
        rd_word_o = entries[rd_idx_i];
    end

endmodule

// File: rtl/stage1_decompressor.sv
// Stage-1 decompressor top: prefix decode, word reconstruction against the
// dictionary, one-deep output register and valid/ready handshake.
module stage1_decompressor
    import cpack_pkg::*;
#(
    parameter int unsigned WIDTH  = CP_WIDTH,
    parameter int unsigned WORDS  = CP_WORDS,
    parameter int unsigned CODE_W = 34
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [CODE_W-1:0] code_i,
    input  logic              code_valid_i,
    output logic              code_ready_o,
    output logic [5:0]        code_len_o,
    output logic [WIDTH-1:0]  word_o,
    output logic              word_valid_o,
    input  logic              word_ready_i,
    output logic              err_o
);

    localparam int unsigned IDX_W = $clog2(WORDS);

    cp_code_e         kind;
    logic [IDX_W-1:0] rd_idx;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] dec_word;
    logic             accept;
    logic             push;

    // Handshake: ready depends only on flush and the output register state
    always_comb begin
        code_ready_o = !flush_i && (!word_valid_o || word_ready_i);
        accept       = code_valid_i && code_ready_o;
    end

    // Prefix decode, length and word reconstruction
    always_comb begin
        kind       = cp_classify(code_i[CODE_W-1 -: 4]);
        code_len_o = cp_code_len(kind);
        rd_idx     = (kind == CP_C_MMMM) ? code_i[CODE_W-3 -: IDX_W]
                                         : code_i[CODE_W-5 -: IDX_W];
        push       = accept && cp_pushes(kind);
        dec_word   = '0;
        case (kind)
            CP_C_XXXX: dec_word = code_i[WIDTH-1:0];
            CP_C_MMMM: dec_word = rd_word;
            CP_C_MMXX: dec_word = {rd_word[WIDTH-1:16], code_i[CODE_W-9 -: 16]};
            CP_C_ZZZX: dec_word[7:0] = code_i[CODE_W-5 -: 8];
            CP_C_MMMX: dec_word = {rd_word[WIDTH-1:8], code_i[CODE_W-9 -: 8]};
            default:   dec_word = '0;
        endcase
    end

    cpack_dictionary #(
        .WIDTH (WIDTH),
        .WORDS (WORDS)
    ) u_dict (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .push_i      (push),
        .push_word_i (dec_word),
        .rd_idx_i    (rd_idx),
        .rd_word_o   (rd_word)
    );

    // Output register, valid flag and sticky illegal-prefix flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_o       <= '0;
            word_valid_o <= 1'b0;
            err_o        <= 1'b0;
        end else if (accept) begin
            word_o       <= dec_word;
            word_valid_o <= 1'b1;
            if (kind == CP_C_ILLEGAL) begin
                err_o <= 1'b1;
            end
        end else if (word_ready_i) begin
            word_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stage1_decompressor.sv
// Scoreboard bench for stage1_decompressor: expected words are queued at
// the accepting cycle and compared when the sink takes each output word.
module tb_stage1_decompressor;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [33:0] code_i = '0;
    logic        code_valid_i = 1'b0;
    logic        code_ready_o;
    logic [5:0]  code_len_o;
    logic [31:0] word_o;
    logic        word_valid_o;
    logic        word_ready_i = 1'b1;
    logic        err_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] sb_q [$];

    stage1_decompressor #(
        .WIDTH  (32),
        .WORDS  (16),
        .CODE_W (34)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .code_i       (code_i),
        .code_valid_i (code_valid_i),
        .code_ready_o (code_ready_o),
        .code_len_o   (code_len_o),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sink side: a word transfers on the next edge when valid and ready
    always @(negedge clk_i) begin
        if (!rst_i && word_valid_o && word_ready_i) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_word", {32'h0, word_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("word", {32'h0, word_o}, {32'h0, sb_q.pop_front()});
            end
        end
    end

    // Present one code, check its length, queue the expected word on accept
    task automatic send(input logic [33:0] code, input logic [31:0] exp_word,
                        input logic [5:0] exp_len);
        bit done = 0;
        code_i       = code;
        code_valid_i = 1'b1;
        @(negedge clk_i);
        check("code_len", {58'h0, code_len_o}, {58'h0, exp_len});
        for (int i = 0; i < 50 && !done; i++) begin
            if (i != 0) @(negedge clk_i);
            if (code_ready_o) begin
                sb_q.push_back(exp_word);
                done = 1;
            end
        end
        if (!done) check("send_timeout", 64'h0, 64'h1);
        @(posedge clk_i);
        #1;
        code_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk_i);
        check("drain_empty", {32'h0, sb_q.size()}, 64'h0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic flush_cycle();
        flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_ready_low", {63'h0, code_ready_o}, 64'h0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
    endtask

    function automatic logic [33:0] c_xxxx(input logic [31:0] w);
        return {2'b01, w};
    endfunction

    function automatic logic [33:0] c_mmmm(input logic [3:0] idx);
        return {2'b10, idx, 28'h0};
    endfunction

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_word", {32'h0, word_o}, 64'h0);
        check("rst_valid", {63'h0, word_valid_o}, 64'h0);
        check("rst_err", {63'h0, err_o}, 64'h0);
        check("rst_wr_ptr", {60'h0, dut.u_dict.wr_ptr}, 64'h0);
        check("rst_ready", {63'h0, code_ready_o}, 64'h1);
        @(posedge clk_i);
        #1;

        // zzzx: small byte, no push
        send({4'b1101, 8'h0A, 22'h0}, 32'h0000_000A, 6'd12);
        drain();
        check("zzzx_wr_ptr", {60'h0, dut.u_dict.wr_ptr}, 64'h0);

        // xxxx then mmmm reuse of the just-pushed word
        send(c_xxxx(32'h1234_5678), 32'h1234_5678, 6'd34);
        send(c_mmmm(4'h0), 32'h1234_5678, 6'd6);
        drain();
        check("mmmm_wr_ptr", {60'h0, dut.u_dict.wr_ptr}, 64'h1);

        // partial matches against a fresh dictionary
        flush_cycle();
        send(c_xxxx(32'hAABB_CCDD), 32'hAABB_CCDD, 6'd34);
        send({4'b1110, 4'h0, 8'h2D, 18'h0}, 32'hAABB_CC2D, 6'd16);
        send({4'b1100, 4'h1, 16'h1122, 10'h0}, 32'hAABB_1122, 6'd24);
        send({2'b00, 32'hFFFF_FFFF}, 32'h0, 6'd2);
        drain();
        check("partial_wr_ptr", {60'h0, dut.u_dict.wr_ptr}, 64'h3);

        // pointer wrap: 17 pushes overwrite entry 0 with the last value
        flush_cycle();
        for (int unsigned v = 1; v <= 17; v++) begin
            send(c_xxxx(32'(v)), 32'(v), 6'd34);
        end
        send(c_mmmm(4'h0), 32'd17, 6'd6);
        send(c_mmmm(4'h1), 32'd2, 6'd6);
        drain();
        check("wrap_wr_ptr", {60'h0, dut.u_dict.wr_ptr}, 64'h1);

        // stall: output held, input blocked for three cycles
        word_ready_i = 1'b0;
        send(c_xxxx(32'hCAFE_F00D), 32'hCAFE_F00D, 6'd34);
        fork
            send(c_xxxx(32'h0BAD_BEEF), 32'h0BAD_BEEF, 6'd34);
            begin
                repeat (3) begin
                    @(negedge clk_i);
                    check("stall_word", {32'h0, word_o}, {32'h0, 32'hCAFE_F00D});
                    check("stall_ready", {63'h0, code_ready_o}, 64'h0);
                    check("stall_sb_depth", {32'h0, sb_q.size()}, 64'h1);
                end
                @(posedge clk_i);
                #1;
                word_ready_i = 1'b1;
                @(negedge clk_i);
                check("unstall_ready", {63'h0, code_ready_o}, 64'h1);
            end
        join
        drain();

        // flush coinciding with a code: code waits and sees cleared entries
        send(c_xxxx(32'h0000_0005), 32'h0000_0005, 6'd34);
        drain();
        flush_i = 1'b1;
        fork
            send(c_mmmm(4'h0), 32'h0, 6'd6);
            begin
                @(negedge clk_i);
                check("flush_code_blocked", {63'h0, code_ready_o}, 64'h0);
                @(posedge clk_i);
                #1;
                flush_i = 1'b0;
            end
        join
        drain();
        check("flush_wr_ptr", {60'h0, dut.u_dict.wr_ptr}, 64'h0);

        // illegal prefix: zero word, sticky error
        send({4'b1111, 30'h3FFF_FFFF}, 32'h0, 6'd4);
        drain();
        check("illegal_err", {63'h0, err_o}, 64'h1);
        send({2'b00, 32'h0}, 32'h0, 6'd2);
        drain();
        check("err_sticky", {63'h0, err_o}, 64'h1);

        // reset mid-stream drops a held word
        word_ready_i = 1'b0;
        send(c_xxxx(32'h0000_0077), 32'h0000_0077, 6'd34);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        sb_q.delete();
        @(negedge clk_i);
        check("rst2_valid", {63'h0, word_valid_o}, 64'h0);
        check("rst2_word", {32'h0, word_o}, 64'h0);
        check("rst2_err", {63'h0, err_o}, 64'h0);
        check("rst2_wr_ptr", {60'h0, dut.u_dict.wr_ptr}, 64'h0);
        word_ready_i = 1'b1;
        @(posedge clk_i);
        #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
